// File: rtl/div32_seq.sv
// Multicycle restoring divider (quotient -> LO, remainder -> HI) with start/busy/done handshake.
// Define DIV_SIGNED_EN to honour signed_op (abs-value on entry, sign fixup on exit).
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// RUN   | one restoring iteration per edge, count 0..WIDTH-1
// DONE  | apply fixup, publish quot/rem, pulse done
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    count;
  logic             dz;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign busy = (state != IDLE);

  // Partial remainder is WIDTH+1 bits so the borrow in t is the exact sign.
  assign r_sh = {r, q[WIDTH-1]};
  assign t    = r_sh - {1'b0, d};

`ifdef DIV_SIGNED_EN
  logic sa;
  logic sb;
  logic neg_q;
  logic neg_r;

  assign sa    = signed_op & dividend[WIDTH-1];
  assign sb    = signed_op & divisor[WIDTH-1];
  assign a_in  = sa ? (~dividend + 1'b1) : dividend;
  assign b_in  = sb ? (~divisor + 1'b1) : divisor;
  assign q_fix = neg_q ? (~q + 1'b1) : q;
  assign r_fix = neg_r ? (~r + 1'b1) : r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_q <= sa ^ sb;
      neg_r <= sa;
    end
  end
`else
  logic unused_signed_op;

  assign unused_signed_op = signed_op;
  assign a_in  = dividend;
  assign b_in  = divisor;
  assign q_fix = q;
  assign r_fix = r;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      r        <= '0;
      q        <= '0;
      d        <= '0;
      count    <= '0;
      dz       <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      quot     <= '0;
      rem      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            r     <= '0;
            d     <= b_in;
            count <= '0;
            if (divisor == '0) begin
              // Raw dividend is kept in q so it can be returned as the remainder.
              q     <= dividend;
              dz    <= 1'b1;
              state <= DONE;
            end else begin
              q     <= a_in;
              dz    <= 1'b0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            if (!t[WIDTH]) begin
              r <= t[WIDTH-1:0];
              q <= {q[WIDTH-2:0], 1'b1};
            end else begin
              r <= r_sh[WIDTH-1:0];
              q <= {q[WIDTH-2:0], 1'b0};
            end
            count <= count + 1'b1;
            if (count == LAST) state <= DONE;
          end
        end
        DONE: begin
          state    <= IDLE;
          done     <= 1'b1;
          div_zero <= dz;
          if (dz) begin
            quot <= '1;
            rem  <= q;
          end else begin
            quot <= q_fix;
            rem  <= r_fix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
